// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg : shared core constants and types for the writeback arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int c_ADDR_W       = 5;
  localparam int c_DATA_W       = 32;
  localparam int c_STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  // Counter must be able to hold the limit value itself.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter_if : requester A/B handshakes and register-file write port
// Revision: 1.0
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                a_valid;
  logic [c_ADDR_W-1:0] a_addr;
  logic [c_DATA_W-1:0] a_data;
  logic                a_stall;

  logic                b_valid;
  logic [c_ADDR_W-1:0] b_addr;
  logic [c_DATA_W-1:0] b_data;
  logic                b_ready;

  logic                write;
  logic [c_ADDR_W-1:0] inaddress;
  logic [c_DATA_W-1:0] in;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_stall, b_ready, write, inaddress, in
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_stall, b_ready, write, inaddress, in
  );

endinterface
`default_nettype wire

// File: rtl/wb_starve_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_starve_counter : saturating wait counter with clear and limit flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_starve_counter
  import wb_port_arbiter_pkg::*;
#(
  parameter int LIMIT = c_STARVE_LIMIT,
  parameter int WIDTH = cnt_width(LIMIT)
) (
  input  wire logic CLK,
  input  wire logic RESET,
  input  wire logic inc,
  input  wire logic clr,
  output logic      at_limit
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; the count parks at LIMIT.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      r_count <= '0;
    end else if (inc && !at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign at_limit = (r_count == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter : shares one register-file write port between A and B
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  wb_port_arbiter_if.slave bus
);

  logic                w_a_real;
  logic                w_b_real;
  logic                w_conflict;
  logic                w_force;
  logic                w_at_limit;
  logic                w_b_ready;
  logic                w_a_stall;
  logic                w_cnt_inc;
  logic                w_cnt_clr;
  grant_e              w_grant;

  logic                r_write;
  logic [c_ADDR_W-1:0] r_inaddress;
  logic [c_DATA_W-1:0] r_in;

  // x0 requests are accepted but never occupy the write slot.
  always_comb begin
    w_a_real   = bus.a_valid && (bus.a_addr != '0);
    w_b_real   = bus.b_valid && (bus.b_addr != '0);
    w_conflict = w_a_real && w_b_real && (bus.a_addr != bus.b_addr);
    w_force    = w_conflict && w_at_limit;

    w_grant = GRANT_NONE;
    if (!RESET) begin
      if (w_a_real && !w_force) begin
        w_grant = GRANT_A;
      end else if (w_b_real) begin
        w_grant = GRANT_B;
      end
    end

    // Same-address B is consumed alongside A and silently dropped.
    w_b_ready = !RESET && bus.b_valid && !(w_conflict && !w_at_limit);
    w_a_stall = !RESET && w_force;

    w_cnt_inc = bus.b_valid && !w_b_ready;
    w_cnt_clr = !bus.b_valid || w_b_ready;
  end

  wb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .inc      (w_cnt_inc),
    .clr      (w_cnt_clr),
    .at_limit (w_at_limit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write     <= 1'b0;
      r_inaddress <= '0;
      r_in        <= '0;
    end else begin
      r_write <= (w_grant != GRANT_NONE);
      case (w_grant)
        GRANT_A: begin
          r_inaddress <= bus.a_addr;
          r_in        <= bus.a_data;
        end
        GRANT_B: begin
          r_inaddress <= bus.b_addr;
          r_in        <= bus.b_data;
        end
        default: begin
          r_inaddress <= r_inaddress;
          r_in        <= r_in;
        end
      endcase
    end
  end

  assign bus.a_stall   = w_a_stall;
  assign bus.b_ready   = w_b_ready;
  assign bus.write     = r_write;
  assign bus.inaddress = r_inaddress;
  assign bus.in        = r_in;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter : directed self-checking bench for wb_port_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .STARVE_LIMIT (3)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
  endtask

  // Inputs change at posedge+1; combinational checks at posedge+5,
  // registered checks at the following posedge+1.
  task automatic mid();
    #4;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b1, 5'd5, 32'h1111, 1'b1, 5'd6, 32'h2222);
    edge1();
    edge1();
    mid();
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_a_stall", 32'(bus.a_stall), 32'd0);
    edge1();
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_inaddress", 32'(bus.inaddress), 32'd0);
    chk("rst_in", bus.in, 32'd0);

    // A only
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    mid();
    chk("aonly_a_stall", 32'(bus.a_stall), 32'd0);
    chk("aonly_b_ready", 32'(bus.b_ready), 32'd0);
    edge1();
    chk("aonly_write", 32'(bus.write), 32'd1);
    chk("aonly_inaddress", 32'(bus.inaddress), 32'd5);
    chk("aonly_in", bus.in, 32'h0000_1234);

    // Idle: pulse ends, address/data hold
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge1();
    chk("idle_write", 32'(bus.write), 32'd0);
    chk("idle_hold_addr", 32'(bus.inaddress), 32'd5);
    chk("idle_hold_in", bus.in, 32'h0000_1234);

    // B only
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'hCAFE);
    mid();
    chk("bonly_b_ready", 32'(bus.b_ready), 32'd1);
    edge1();
    chk("bonly_write", 32'(bus.write), 32'd1);
    chk("bonly_inaddress", 32'(bus.inaddress), 32'd6);
    chk("bonly_in", bus.in, 32'h0000_CAFE);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge1();

    // Conflict: A wins three times, then B is forced through
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 1), 32'(32'hA0 + k), 1'b1, 5'd7, 32'hBEEF);
      mid();
      chk("conf_b_ready_lo", 32'(bus.b_ready), 32'd0);
      chk("conf_a_stall_lo", 32'(bus.a_stall), 32'd0);
      edge1();
      chk("conf_a_write", 32'(bus.write), 32'd1);
      chk("conf_a_addr", 32'(bus.inaddress), 32'(k + 1));
      chk("conf_a_data", bus.in, 32'(32'hA0 + k));
    end
    drive(1'b1, 5'd4, 32'hA3, 1'b1, 5'd7, 32'hBEEF);
    mid();
    chk("force_b_ready", 32'(bus.b_ready), 32'd1);
    chk("force_a_stall", 32'(bus.a_stall), 32'd1);
    edge1();
    chk("force_b_write", 32'(bus.write), 32'd1);
    chk("force_b_addr", 32'(bus.inaddress), 32'd7);
    chk("force_b_data", bus.in, 32'h0000_BEEF);
    drive(1'b1, 5'd4, 32'hA3, 1'b0, 5'd0, 32'h0);
    mid();
    chk("held_a_stall", 32'(bus.a_stall), 32'd0);
    edge1();
    chk("held_a_write", 32'(bus.write), 32'd1);
    chk("held_a_addr", 32'(bus.inaddress), 32'd4);
    chk("held_a_data", bus.in, 32'h0000_00A3);

    // Supersede: same address, A data wins, B consumed and dropped
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    mid();
    chk("sup_b_ready", 32'(bus.b_ready), 32'd1);
    chk("sup_a_stall", 32'(bus.a_stall), 32'd0);
    edge1();
    chk("sup_write", 32'(bus.write), 32'd1);
    chk("sup_addr", 32'(bus.inaddress), 32'd9);
    chk("sup_data", bus.in, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge1();
    chk("sup_no_late1", 32'(bus.write), 32'd0);
    edge1();
    chk("sup_no_late2", 32'(bus.write), 32'd0);

    // A to x0 frees the slot for B
    drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h5);
    mid();
    chk("x0a_b_ready", 32'(bus.b_ready), 32'd1);
    edge1();
    chk("x0a_write", 32'(bus.write), 32'd1);
    chk("x0a_addr", 32'(bus.inaddress), 32'd3);
    chk("x0a_data", bus.in, 32'h5);

    // B to x0 accepted immediately while A writes
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'h33);
    mid();
    chk("x0b_b_ready", 32'(bus.b_ready), 32'd1);
    chk("x0b_a_stall", 32'(bus.a_stall), 32'd0);
    edge1();
    chk("x0b_write", 32'(bus.write), 32'd1);
    chk("x0b_addr", 32'(bus.inaddress), 32'd2);
    chk("x0b_data", bus.in, 32'h22);

    // A alone to x0: no pulse, previous address held
    drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
    edge1();
    chk("x0only_write", 32'(bus.write), 32'd0);
    chk("x0only_hold", 32'(bus.inaddress), 32'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge1();

    // Reset in the cycle B would be forced
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 1), 32'(32'hA0 + k), 1'b1, 5'd7, 32'hBEEF);
      mid();
      chk("rc_b_ready_lo", 32'(bus.b_ready), 32'd0);
      edge1();
    end
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hA3, 1'b1, 5'd7, 32'hBEEF);
    mid();
    chk("rc_rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rc_rst_a_stall", 32'(bus.a_stall), 32'd0);
    edge1();
    chk("rc_rst_write", 32'(bus.write), 32'd0);
    chk("rc_rst_addr", 32'(bus.inaddress), 32'd0);
    chk("rc_rst_in", bus.in, 32'd0);

    // Counter restarted from 0: A wins three more times before B is forced
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd4, 32'hA3, 1'b1, 5'd7, 32'hBEEF);
      mid();
      chk("post_b_ready_lo", 32'(bus.b_ready), 32'd0);
      chk("post_a_stall_lo", 32'(bus.a_stall), 32'd0);
      edge1();
      chk("post_a_write", 32'(bus.write), 32'd1);
      chk("post_a_addr", 32'(bus.inaddress), 32'd4);
    end
    mid();
    chk("post_force_b_ready", 32'(bus.b_ready), 32'd1);
    edge1();
    chk("post_force_addr", 32'(bus.inaddress), 32'd7);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    edge1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
